mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Second-generation multi-cycle control sequencer for the CPU core. It replaces the fixed single-cycle state walk with a parametrised FSM.
- Memory accesses use a ready handshake with bounded wait states and a timeout fault. Halt is requested cleanly at instruction boundaries. Push/pop drive stack-pointer strobes at the correct pre/post points.
- Sits between the IR/status registers and the datapath. Consumes decoded IR fields and drives datapath strobes.

Parameters:
- IMM_W, 16, width of immediate field; imm_mask output = (1<<IMM_W)-1 zero-extended to 32 bits.
- TIMEOUT, 255, maximum consecutive cycles a memory request may wait for mem_ready before FAULT; legal range 1..65535.
- TO_W, $clog2(TIMEOUT+1), width of the wait counter; derived, not overridden.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave STOP/FAULT and begin fetching; level, sampled each cycle
- halt_req  in  1  request stop at the next instruction boundary; level
- ir_op  in  6  opcode. [5:4]=00 ALU/MOV, 01 LOAD, 10 STORE, 11 MISC. MISC [3:0]: 0 NOP, 1 PUSH, 2 POP, 3 HALT, others NOP
- ir_cond  in  4  condition: 0 NONE, 1 EQ, 2 NE, 3 LTU, 4 GTU, 5 LEU, 6 GEU, 7 LTS, 8 GTS, 9 LES, 10 GES, 11-15 always
- ir_set_status  in  1  ALU instruction updates flags
- status  in  4  {negative, overflow, carry, zero} (bits 3..0)
- mem_ready  in  1  memory accepts/returns data this cycle
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- ld_ir  out  1  load instruction register
- ld_reg  out  1  load register-file destination
- ld_status  out  1  load status register
- oe_alu  out  1  ALU drives result bus
- pc_inc  out  1  post-increment PC
- sp_dec  out  1  pre-decrement SP
- sp_inc  out  1  post-increment SP
- imm_mask  out  32  immediate mask (constant)
- retire  out  1  one-cycle pulse when an instruction completes or is skipped
- busy  out  1  state not STOP/FAULT
- fault  out  1  memory timeout occurred

Behaviour:
- States: STOP, FETCH, DECODE, EXEC, MEM, FAULT. Reset → STOP, wait counter 0.
- All outputs are combinational from state, the IR fields and mem_ready. In STOP every strobe is 0, busy=0, fault=0.
- STOP: start=1 → FETCH.
- FETCH: mem_rd=1. When mem_ready=1: ld_ir=1, pc_inc=1 that same cycle, → DECODE.
- DECODE: evaluates the condition on status. Conditions:
  - EQ: z. NE: !z.
  - LTU: !c. GTU: c&!z. LEU: !c|z. GEU: c.
  - LTS: n!=v. GTS: !z&(n==v). LES: z|(n!=v). GES: n==v.
  - Condition false: retire=1; go to STOP if halt_req, else FETCH.
  - ALU → EXEC.
  - LOAD/STORE/POP → MEM.
  - PUSH: sp_dec=1 in DECODE, → MEM.
  - NOP: retire=1, boundary.
  - HALT: retire=1, → STOP regardless of start.
- EXEC: oe_alu=1, ld_reg=1, ld_status=ir_set_status, retire=1, boundary. Exactly one cycle.
- MEM: LOAD/POP assert mem_rd; STORE/PUSH assert mem_wr. Held steady until mem_ready. On the mem_ready cycle:
  - LOAD/POP: ld_reg=1; POP also sp_inc=1.
  - retire=1, boundary.
- Boundary: halt_req=1 → STOP, else → FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on any mem_ready.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0 → FAULT next cycle; no ld_ir/ld_reg/sp_inc is issued.
  - mem_ready in the same cycle the count hits TIMEOUT: the access completes, no fault.
- FAULT: all strobes 0, fault=1, busy=0. start=1 → FETCH, fault clears.
- Latency with mem_ready tied high: ALU = 3 cycles, LOAD = 3, NOP/skipped = 2.
- rst_n asserted mid-access: immediate STOP, all strobes 0 asynchronously. Nothing is retired.
- Never mem_rd and mem_wr together. Never sp_dec and sp_inc together.

Test Plan:
- Reset, start=1, mem_ready=1, ir_op=0x00, cond=0, ir_set_status=1 → FETCH/DECODE/EXEC; EXEC shows ld_reg=ld_status=oe_alu=1; retire at cycle 3.
- ir_cond=1 (EQ), status=4'b0000 → DECODE retires, no ld_reg. Repeat with status=4'b0001 → EXEC taken.
- LOAD with mem_ready low 4 cycles then high → mem_rd held 5 MEM cycles; ld_reg only on the ready cycle; no fault.
- TIMEOUT=3, mem_ready stuck 0 in FETCH → FAULT after 3 wait cycles; fault=1, no ld_ir. Then start=1 → fault=0, FETCH.
- PUSH then POP: sp_dec single pulse in DECODE with mem_wr next; POP sp_inc+ld_reg only on the mem_ready cycle.
- halt_req raised mid-LOAD wait → instruction completes and retires, then STOP. HALT opcode with start=1 → STOP. rst_n low mid-MEM → all outputs 0 immediately.

Source files
------------

// File: rtl/mc_control_if.sv
// Memory request/ready handshake between the control sequencer
// and the memory port.
interface mc_control_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem walk with
// bounded memory wait states, timeout fault and clean halting.
module mc_control #(
  parameter  int IMM_W   = 16,
  parameter  int TIMEOUT = 255,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic [5:0]  ir_op,
  input  logic [3:0]  ir_cond,
  input  logic        ir_set_status,
  input  logic [3:0]  status,
  mc_control_if.master mem,
  output logic        ld_ir,
  output logic        ld_reg,
  output logic        ld_status,
  output logic        oe_alu,
  output logic        pc_inc,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic [31:0] imm_mask,
  output logic        retire,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_STOP,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_FAULT
  } state_t;

  localparam logic [63:0] MASK64 = (64'd1 << IMM_W) - 64'd1;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_next;

  logic   w_mem_rd;
  logic   w_mem_wr;
  logic   w_cond_ok;
  logic   w_to;
  state_t w_bound;

  logic w_n, w_v, w_c, w_z;
  logic w_alu, w_load, w_store, w_misc;
  logic w_push, w_pop, w_halt;
  logic w_rd_type, w_wr_type;

  assign {w_n, w_v, w_c, w_z} = status;

  assign w_alu   = (ir_op[5:4] == 2'b00);
  assign w_load  = (ir_op[5:4] == 2'b01);
  assign w_store = (ir_op[5:4] == 2'b10);
  assign w_misc  = (ir_op[5:4] == 2'b11);
  assign w_push  = w_misc && (ir_op[3:0] == 4'd1);
  assign w_pop   = w_misc && (ir_op[3:0] == 4'd2);
  assign w_halt  = w_misc && (ir_op[3:0] == 4'd3);

  assign w_rd_type = w_load  | w_pop;
  assign w_wr_type = w_store | w_push;

  assign w_bound = halt_req ? S_STOP : S_FETCH;

  // Fault when this waiting cycle is the TIMEOUT-th one in a row
  assign w_to = !mem.mem_ready &&
                (r_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_cond_ok = 1'b1;
    case (ir_cond)
      4'd1:    w_cond_ok = w_z;
      4'd2:    w_cond_ok = !w_z;
      4'd3:    w_cond_ok = !w_c;
      4'd4:    w_cond_ok = w_c && !w_z;
      4'd5:    w_cond_ok = !w_c || w_z;
      4'd6:    w_cond_ok = w_c;
      4'd7:    w_cond_ok = (w_n != w_v);
      4'd8:    w_cond_ok = !w_z && (w_n == w_v);
      4'd9:    w_cond_ok = w_z || (w_n != w_v);
      4'd10:   w_cond_ok = (w_n == w_v);
      default: w_cond_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_STOP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    ld_ir      = 1'b0;
    ld_reg     = 1'b0;
    ld_status  = 1'b0;
    oe_alu     = 1'b0;
    pc_inc     = 1'b0;
    sp_dec     = 1'b0;
    sp_inc     = 1'b0;
    retire     = 1'b0;
    case (r_state)
      S_STOP: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (mem.mem_ready) begin
          ld_ir  = 1'b1;
          pc_inc = 1'b1;
          w_next = S_DECODE;
        end else if (w_to) begin
          w_next = S_FAULT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (!w_cond_ok) begin
          retire = 1'b1;
          w_next = w_bound;
        end else begin
          unique case (1'b1)
            w_alu: w_next = S_EXEC;
            w_push: begin
              sp_dec = 1'b1;
              w_next = S_MEM;
            end
            w_load, w_store, w_pop:
              w_next = S_MEM;
            w_halt: begin
              retire = 1'b1;
              w_next = S_STOP;
            end
            default: begin
              retire = 1'b1;
              w_next = w_bound;
            end
          endcase
        end
      end
      S_EXEC: begin
        oe_alu    = 1'b1;
        ld_reg    = 1'b1;
        ld_status = ir_set_status;
        retire    = 1'b1;
        w_next    = w_bound;
      end
      S_MEM: begin
        w_mem_rd = w_rd_type;
        w_mem_wr = w_wr_type;
        if (mem.mem_ready) begin
          ld_reg = w_rd_type;
          sp_inc = w_pop;
          retire = 1'b1;
          w_next = w_bound;
        end else if (w_to) begin
          w_next = S_FAULT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_FAULT: begin
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_STOP;
    endcase
  end

  assign mem.mem_rd = w_mem_rd;
  assign mem.mem_wr = w_mem_wr;
  assign busy       = (r_state != S_STOP) &&
                      (r_state != S_FAULT);
  assign fault      = (r_state == S_FAULT);
  assign imm_mask   = MASK64[31:0];

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: default-timeout instance plus a
// TIMEOUT=3 instance for the fault and wait-limit cases.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic [5:0] ir_op = '0;
  logic [3:0] ir_cond = '0;
  logic       ir_set_status = 1'b0;
  logic [3:0] status = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_control_if m_if ();
  mc_control_if t_if ();

  logic        ld_ir, ld_reg, ld_status, oe_alu;
  logic        pc_inc, sp_dec, sp_inc, retire, busy, fault;
  logic [31:0] imm_mask;
  logic        t_ld_ir, t_ld_reg, t_ld_status, t_oe_alu;
  logic        t_pc_inc, t_sp_dec, t_sp_inc, t_retire;
  logic        t_busy, t_fault;
  logic [31:0] t_imm_mask;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .halt_req(halt_req), .ir_op(ir_op), .ir_cond(ir_cond),
    .ir_set_status(ir_set_status), .status(status),
    .mem(m_if.master),
    .ld_ir(ld_ir), .ld_reg(ld_reg), .ld_status(ld_status),
    .oe_alu(oe_alu), .pc_inc(pc_inc), .sp_dec(sp_dec),
    .sp_inc(sp_inc), .imm_mask(imm_mask), .retire(retire),
    .busy(busy), .fault(fault)
  );

  mc_control #(.TIMEOUT(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start),
    .halt_req(halt_req), .ir_op(ir_op), .ir_cond(ir_cond),
    .ir_set_status(ir_set_status), .status(status),
    .mem(t_if.master),
    .ld_ir(t_ld_ir), .ld_reg(t_ld_reg),
    .ld_status(t_ld_status), .oe_alu(t_oe_alu),
    .pc_inc(t_pc_inc), .sp_dec(t_sp_dec), .sp_inc(t_sp_inc),
    .imm_mask(t_imm_mask), .retire(t_retire),
    .busy(t_busy), .fault(t_fault)
  );

  // {busy,fault,rd,wr, ir,reg,status,alu, pc,spdec,spinc,retire}
  logic [11:0] obs, obs_t;
  assign obs = {busy, fault, m_if.mem_rd, m_if.mem_wr,
                ld_ir, ld_reg, ld_status, oe_alu,
                pc_inc, sp_dec, sp_inc, retire};
  assign obs_t = {t_busy, t_fault, t_if.mem_rd, t_if.mem_wr,
                  t_ld_ir, t_ld_reg, t_ld_status, t_oe_alu,
                  t_pc_inc, t_sp_dec, t_sp_inc, t_retire};

  localparam logic [11:0] E_STOP  = 12'b00_00_0000_0000;
  localparam logic [11:0] E_FRDY  = 12'b10_10_1000_1000;
  localparam logic [11:0] E_RWAIT = 12'b10_10_0000_0000;
  localparam logic [11:0] E_DEC   = 12'b10_00_0000_0000;
  localparam logic [11:0] E_DRET  = 12'b10_00_0000_0001;
  localparam logic [11:0] E_DPUSH = 12'b10_00_0000_0100;
  localparam logic [11:0] E_EXS   = 12'b10_00_0111_0001;
  localparam logic [11:0] E_EXN   = 12'b10_00_0101_0001;
  localparam logic [11:0] E_LDONE = 12'b10_10_0100_0001;
  localparam logic [11:0] E_WWAIT = 12'b10_01_0000_0000;
  localparam logic [11:0] E_WDONE = 12'b10_01_0000_0001;
  localparam logic [11:0] E_POPD  = 12'b10_10_0100_0011;
  localparam logic [11:0] E_FAULT = 12'b01_00_0000_0000;

  typedef struct packed {
    logic        s;
    logic        h;
    logic        r;
    logic [3:0]  st;
    logic [5:0]  op;
    logic [11:0] e;
  } vec_t;

  function automatic vec_t mk(logic s, logic h, logic r,
                              logic [3:0] st, logic [5:0] op,
                              logic [11:0] e);
    vec_t v;
    v.s = s; v.h = h; v.r = r;
    v.st = st; v.op = op; v.e = e;
    return v;
  endfunction

  task automatic set_rdy(input logic r);
    m_if.mem_ready = r;
    t_if.mem_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    ir_op = '0;
    ir_cond = '0;
    ir_set_status = 1'b0;
    status = '0;
    set_rdy(1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    set_rdy(1'b1);
    #2;
    checks++;
    if (obs !== E_STOP || obs_t !== E_STOP) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b exp=%b",
               obs, obs_t, E_STOP);
    end
    checks++;
    if (imm_mask !== 32'h0000_FFFF) begin
      failures++;
      $display("FAIL imm_mask got=%h exp=0000ffff", imm_mask);
    end
    do_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (obs !== E_STOP) begin
        failures++;
        $display("FAIL stop_idle c%0d got=%b exp=%b",
                 k, obs, E_STOP);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    vec_t q[$];
    do_reset();
    ir_set_status = 1'b1;
    q.push_back(mk(1, 0, 1, 4'h0, 6'h00, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_DEC));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_EXS));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_FRDY));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL alu c%0d got=%b exp=%b", k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cond_eq();
    vec_t q[$];
    do_reset();
    ir_cond = 4'd1;
    ir_set_status = 1'b1;
    q.push_back(mk(1, 0, 1, 4'h0, 6'h00, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_DRET));
    q.push_back(mk(0, 0, 1, 4'h1, 6'h00, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h1, 6'h00, E_DEC));
    q.push_back(mk(0, 0, 1, 4'h1, 6'h00, E_EXS));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL cond_eq c%0d got=%b exp=%b",
                 k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  // {cond, status, taken}; retire in DECODE means skipped
  task automatic test_cond_table();
    logic [8:0] tbl [12] = '{
      {4'd2,  4'b0000, 1'b1}, {4'd3,  4'b0000, 1'b1},
      {4'd4,  4'b0011, 1'b0}, {4'd5,  4'b0010, 1'b0},
      {4'd6,  4'b0010, 1'b1}, {4'd7,  4'b1000, 1'b1},
      {4'd8,  4'b0000, 1'b1}, {4'd8,  4'b1001, 1'b0},
      {4'd9,  4'b0100, 1'b1}, {4'd10, 4'b0100, 1'b0},
      {4'd12, 4'b0000, 1'b1}, {4'd1,  4'b0001, 1'b1}};
    for (int i = 0; i < 12; i++) begin
      do_reset();
      ir_cond = tbl[i][8:5];
      status = tbl[i][4:1];
      start = 1'b1;
      set_rdy(1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (retire !== !tbl[i][0]) begin
        failures++;
        $display("FAIL cond_tbl i%0d cond=%0d st=%b got=%b exp=%b",
                 i, tbl[i][8:5], tbl[i][4:1], retire, !tbl[i][0]);
      end
    end
  endtask

  task automatic test_load_wait();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 1, 4'h0, 6'h10, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_DEC));
    for (int i = 0; i < 4; i++)
      q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_LDONE));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL load_wait c%0d got=%b exp=%b",
                 k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 0, 4'h0, 6'h00, E_STOP));
    for (int i = 0; i < 3; i++)
      q.push_back(mk(0, 0, 0, 4'h0, 6'h00, E_RWAIT));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h00, E_FAULT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_FAULT));
    q.push_back(mk(1, 0, 1, 4'h0, 6'h00, E_FAULT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_DEC));
    for (int i = 0; i < 3; i++)
      q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FAULT));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs_t !== q[k].e) begin
        failures++;
        $display("FAIL timeout c%0d got=%b exp=%b",
                 k, obs_t, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_edge();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 0, 4'h0, 6'h10, E_STOP));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_DEC));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_LDONE));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs_t !== q[k].e) begin
        failures++;
        $display("FAIL to_edge c%0d got=%b exp=%b",
                 k, obs_t, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_push_pop();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 1, 4'h0, 6'h31, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h31, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h31, E_DPUSH));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h31, E_WWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h31, E_WDONE));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h32, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h32, E_DEC));
    q.push_back(mk(0, 0, 0, 4'h0, 6'h32, E_RWAIT));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h32, E_POPD));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h32, E_FRDY));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL push_pop c%0d got=%b exp=%b",
                 k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 1, 4'h0, 6'h10, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_DEC));
    q.push_back(mk(0, 1, 0, 4'h0, 6'h10, E_RWAIT));
    q.push_back(mk(0, 1, 1, 4'h0, 6'h10, E_LDONE));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h10, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h33, E_STOP));
    q.push_back(mk(1, 0, 1, 4'h0, 6'h33, E_STOP));
    q.push_back(mk(1, 0, 1, 4'h0, 6'h33, E_FRDY));
    q.push_back(mk(1, 0, 1, 4'h0, 6'h33, E_DRET));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h33, E_STOP));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL halt c%0d got=%b exp=%b",
                 k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    do_reset();
    q.push_back(mk(1, 0, 1, 4'h0, 6'h00, E_STOP));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_DEC));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h00, E_EXN));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h20, E_FRDY));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h20, E_DEC));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h20, E_WDONE));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h37, E_FRDY));
    q.push_back(mk(0, 1, 1, 4'h0, 6'h37, E_DRET));
    q.push_back(mk(0, 0, 1, 4'h0, 6'h37, E_STOP));
    foreach (q[k]) begin
      start = q[k].s; halt_req = q[k].h; set_rdy(q[k].r);
      status = q[k].st; ir_op = q[k].op;
      #1;
      checks++;
      if (obs !== q[k].e) begin
        failures++;
        $display("FAIL b2b c%0d got=%b exp=%b",
                 k, obs, q[k].e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir_op = 6'h10;
    start = 1'b1;
    set_rdy(1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    set_rdy(1'b0);
    @(posedge clk); #1;
    checks++;
    if (obs !== E_RWAIT) begin
      failures++;
      $display("FAIL rst_mid_pre got=%b exp=%b", obs, E_RWAIT);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_STOP) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=%b", obs, E_STOP);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    set_rdy(1'b0);
    test_reset();
    test_alu();
    test_cond_eq();
    test_cond_table();
    test_load_wait();
    test_timeout();
    test_timeout_edge();
    test_push_pop();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
